fir_folded_exact: RTL and testbench
===================================

# fir_folded_exact

Folded, exact-arithmetic 10-tap FIR that accepts samples and returns filtered results over a valid/ready stream. It computes the same transfer function as the team's parallel approximate-adder FIR, but with one multiply-accumulate datapath, a circular sample store, and full-precision mod-2^32 adders. It serves two roles: the low-area filter variant, and the golden consumer-side model that the approximate FIR is scored against in system benches.

## Interface

Parameters:
- `TAPS`, 10, filter length. Fixed to 10 by the coefficient set.
- `W`, 32, sample, coefficient and accumulator width (two's complement).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `x_in` in W: input sample.
- `x_valid` in 1: `x_in` is valid.
- `x_ready` out 1: block can accept a sample.
- `y_out` out W: filtered result.
- `y_valid` out 1: `y_out` is valid.
- `y_ready` in 1: downstream accepts `y_out`.

## Operation

- Transfer function: y[n] = Σ h[k]·x[n−k], for k = 0..9.
- Coefficients h[0..9] = 129, 721, 592, 80, 81, 78, −15, −93, 95, 127.
- Arithmetic:
  - All products and sums are truncated to W bits and wrap modulo 2^32.
  - No saturation.
  - The result must be bit-exact against a W-bit integer reference.
- Sample store:
  - 10-entry circular buffer with write pointer `wr_ptr` (0..9, wraps 9→0).
  - All entries are cleared to 0 on reset, so the initial history is zero.
- FSM states:
  - IDLE: `x_ready`=1. On `x_valid`&&`x_ready`, write `x_in` at `wr_ptr`, clear the accumulator, set tap index k=0, go to MAC.
  - MAC: each cycle, acc ← acc + h[k]·buf[(wr_ptr − k) mod 10] (the new sample is visible at k=0). k increments. After k=9, advance `wr_ptr`, load `y_out` ← final acc, go to OUT.
  - OUT: `y_valid`=1 and `y_out` is held stable. On `y_ready`, go to IDLE.
- `x_ready` is high only in IDLE. No input is accepted while MAC or OUT is in progress.
- `y_out` holds its last value after the handshake until the next result is loaded.

## Timing

- Reset values:
  - state = IDLE, `x_ready`=1, `y_valid`=0, `y_out`=0.
  - `wr_ptr`=0, accumulator = 0, all buffer entries = 0.
- Latency: sample accepted at edge T; MAC occupies T+1..T+10; `y_valid` rises after edge T+10. Minimum result-to-accept period is 11 cycles.
- Throughput: one sample per 12 cycles when `y_ready` is tied high (accept, 10 MAC, 1 OUT).
- Backpressure: OUT may persist indefinitely. `y_out` and `y_valid` must not change while waiting.
- `rst` in any state:
  - Returns everything to reset values on the next edge.
  - An in-flight sample is discarded and the history is cleared.
  - `rst` has priority over every handshake in the same cycle.
- `x_valid` while not in IDLE is ignored. The source must hold the sample, per the standard valid/ready rule.

## Structure

- Shared package `fir_pkg`:
  - `W` and `TAPS` constants.
  - The coefficient array `FIR_COEF[0:9]`, shared with the approximate FIR bench so both sides use one source of truth.
  - The FSM state enum (IDLE/MAC/OUT).
- Sub-module `fir_mac`: combinational W-bit `acc + coef·sample`, truncated. It is isolated so the approximate adder can later be swapped in for error studies.
- Top level contains the FSM, the tap counter, the circular buffer and the output register.

## Test plan

- Impulse: x = 1 followed by 10 zeros, `y_ready`=1 → outputs 129, 721, 592, 80, 81, 78, 0xFFFFFFF1, 0xFFFFFFA3, 95, 127, then 0.
- Step: x = 1 repeated 12 times → 129, 850, 1442, 1522, 1603, 1681, 1666, 1573, 1668, 1795, 1795, 1795.
- Wrap: a single x = 0x7FFFFFFF from reset → first y = 0x7FFFFF7F (129·x mod 2^32). All later outputs match the modulo-2^32 reference.
- Backpressure: hold `y_ready`=0 for 20 cycles in OUT → `y_out` stable, `y_valid`=1, `x_ready`=0 throughout. Release → one handshake, then IDLE.
- Reset mid-MAC: assert `rst` at cycle T+5 after accepting x = 5 → `y_valid` never rises. The next impulse x = 1 then yields 129 (history cleared).
- Random stream: 1000 random samples with random `x_valid`/`y_ready` gaps → outputs bit-exact against the scoreboard, with no drops or duplicates.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: constants, coefficient set and FSM states shared by the folded FIR and its benches.
package fir_pkg;
    localparam int W = 32;
    localparam int TAPS = 10;
    // h[6] = -15 and h[7] = -93 in two's complement
    localparam logic [W-1:0] FIR_COEF [0:TAPS-1] = '{
        32'd129, 32'd721, 32'd592, 32'd80, 32'd81,
        32'd78, 32'hFFFF_FFF1, 32'hFFFF_FFA3, 32'd95, 32'd127
    };
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
endpackage

// File: rtl/fir_mac.sv
// fir_mac: W-bit multiply-accumulate, acc + coef*sample wrapping modulo 2^W.
module fir_mac #(
    parameter int W = 32
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] coef,
    input  logic [W-1:0] sample,
    output logic [W-1:0] sum
);
    assign sum = acc + coef * sample;
endmodule

// File: rtl/fir_folded_exact.sv
// fir_folded_exact: 10-tap FIR folded onto one MAC, circular sample store, valid/ready stream.
module fir_folded_exact import fir_pkg::*; #(
    parameter int TAPS = fir_pkg::TAPS,
    parameter int W = fir_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [W-1:0] y_out,
    output logic         y_valid,
    input  logic         y_ready
);
    localparam int PW = $clog2(TAPS);
    localparam logic [PW-1:0] LAST = PW'(TAPS - 1);

    state_t state, state_n;
    logic [W-1:0] mem [TAPS];
    logic [W-1:0] acc, sum;
    logic [PW-1:0] wr_ptr, k, rd_ptr;

    assign x_ready = state == IDLE;
    assign y_valid = state == OUT;
    // newest sample sits at wr_ptr; tap k looks k entries back, wrapping
    assign rd_ptr = wr_ptr >= k ? wr_ptr - k : wr_ptr + PW'(TAPS) - k;

    fir_mac #(.W(W)) u_mac (
        .acc(acc),
        .coef(FIR_COEF[k]),
        .sample(mem[rd_ptr]),
        .sum(sum)
    );

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (x_valid ? MAC : IDLE) :
                  state == MAC  ? (k == LAST ? OUT : MAC) :
                                  (y_ready ? IDLE : OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            k <= '0;
            acc <= '0;
            y_out <= '0;
            for (int i = 0; i < TAPS; i++) mem[i] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && x_valid) begin
                mem[wr_ptr] <= x_in;
                acc <= '0;
                k <= '0;
            end
            if (state == MAC) begin
                acc <= sum;
                k <= k + PW'(1);
                if (k == LAST) begin
                    y_out <= sum;
                    wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_folded_exact.sv
// tb_fir_folded_exact: directed and random stream checks of the folded FIR against a convolution model.
module tb_fir_folded_exact;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] x_in = '0;
    logic        x_valid = 0;
    logic        x_ready;
    logic [31:0] y_out;
    logic        y_valid;
    logic        y_ready = 0;

    int checks = 0;
    int errors = 0;

    logic [31:0] coef [10] = '{32'd129, 32'd721, 32'd592, 32'd80, 32'd81,
                               32'd78, 32'hFFFFFFF1, 32'hFFFFFFA3, 32'd95, 32'd127};
    logic [31:0] hist [10];
    logic [31:0] imp_exp [11] = '{32'd129, 32'd721, 32'd592, 32'd80, 32'd81, 32'd78,
                                  32'hFFFFFFF1, 32'hFFFFFFA3, 32'd95, 32'd127, 32'd0};
    logic [31:0] step_exp [12] = '{32'd129, 32'd850, 32'd1442, 32'd1522, 32'd1603, 32'd1681,
                                   32'd1666, 32'd1573, 32'd1668, 32'd1795, 32'd1795, 32'd1795};

    fir_folded_exact dut (
        .clk(clk),
        .rst(rst),
        .x_in(x_in),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .y_out(y_out),
        .y_valid(y_valid),
        .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_y();
        logic [31:0] s = '0;
        for (int i = 0; i < 10; i++) s = s + coef[i] * hist[i];
        return s;
    endfunction

    task automatic model_push(input logic [31:0] x);
        for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
    endtask

    task automatic do_reset();
        rst = 1;
        x_valid = 0;
        y_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) hist[i] = '0;
        chk("rst_x_ready", 32'(x_ready), 32'd1);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_out", y_out, 32'd0);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] x);
        int n = 0;
        x_in = x;
        x_valid = 1;
        while (!x_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 32'd1);
        @(negedge clk);
        x_valid = 0;
        chk("busy_x_ready", 32'(x_ready), 32'd0);
        model_push(x);
    endtask

    task automatic pop(input logic [31:0] exp, input string tag, input int stall, output int lat);
        int n = 0;
        while (!y_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk({tag, "_valid"}, 32'(y_valid), 32'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_y"}, y_out, exp);
            chk({tag, "_hold_v"}, 32'(y_valid), 32'd1);
            chk({tag, "_hold_xr"}, 32'(x_ready), 32'd0);
        end
        chk(tag, y_out, exp);
        y_ready = 1;
        @(negedge clk);
        y_ready = 0;
        chk({tag, "_dup"}, 32'(y_valid), 32'd0);
        chk({tag, "_idle"}, 32'(x_ready), 32'd1);
        chk({tag, "_keep"}, y_out, exp);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] cur, nxt, e;
        logic pre;
        @(negedge clk);
        do_reset();
        // impulse
        for (int i = 0; i < 11; i++) begin
            push(i == 0 ? 32'd1 : 32'd0);
            pop(imp_exp[i], "impulse", 0, lat);
            if (i == 0) chk("latency", 32'(lat), 32'd10);
        end
        // step
        for (int i = 0; i < 12; i++) begin
            push(32'd1);
            pop(step_exp[i], "step", 0, lat);
        end
        // backpressure: 1795 + 129*2 = 2053
        push(32'd3);
        pop(32'd2053, "backpressure", 20, lat);
        chk("bp_model", model_y(), 32'd2053);
        // wrap
        do_reset();
        push(32'h7FFFFFFF);
        pop(32'h7FFFFF7F, "wrap", 0, lat);
        push(32'h7FFFFFFF);
        pop(model_y(), "wrap2", 1, lat);
        push(32'h80000000);
        pop(model_y(), "wrap3", 0, lat);
        push(32'hFFFFFFFF);
        pop(model_y(), "wrap4", 2, lat);
        // reset mid-MAC
        do_reset();
        push(32'd5);
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) hist[i] = '0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (y_valid) seen++;
            @(negedge clk);
        end
        chk("midmac_no_valid", 32'(seen), 32'd0);
        chk("midmac_x_ready", 32'(x_ready), 32'd1);
        push(32'd1);
        pop(32'd129, "after_reset", 0, lat);
        // random stream
        do_reset();
        cur = $urandom;
        pre = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!pre) repeat ($urandom_range(0, 2)) @(negedge clk);
            push(cur);
            e = model_y();
            nxt = $urandom;
            pre = 1'($urandom_range(0, 1));
            if (pre) begin
                x_in = nxt;
                x_valid = 1;
            end
            pop(e, "random", $urandom_range(0, 3), lat);
            cur = nxt;
        end
        x_valid = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
